// File: rtl/comb_sweep_driver_pkg.sv
// Shared definitions for the exhaustive combinational sweep driver:
// FSM state encodings and default sweep parameters.
package comb_sweep_driver_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam int unsigned DefWidth  = 4;
   localparam int unsigned DefSettle = 1;

endpackage

// File: rtl/comb_sweep_driver_settle_timer.sv
// Settle counter: counts 0..SETTLE-1 while enabled and flags the last cycle
// of each vector's hold window.
module settle_timer #(
   parameter int unsigned SETTLE = 1
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CW'(SETTLE - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/comb_sweep_driver.sv
// Drives every input vector of a combinational block in order, captures its
// output into a truth table and compares the table against a golden value.
module comb_sweep_driver
   import comb_sweep_driver_pkg::*;
#(
   parameter int unsigned             WIDTH  = DefWidth,
   parameter int unsigned             SETTLE = DefSettle,
   parameter logic [(2**WIDTH)-1:0]   EXPECT = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    y,
   output logic [WIDTH-1:0]        data,
   output logic                    busy,
   output logic                    done,
   output logic [(2**WIDTH)-1:0]   table_q,
   output logic [WIDTH:0]          mismatch_cnt,
   output logic                    pass
);

   localparam int unsigned TW = 2 ** WIDTH;
   localparam int unsigned MW = WIDTH + 1;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [TW-1:0]     tab_q, tab_d;
   logic [MW-1:0]     mm_q, mm_d;
   logic              busy_q, done_q, pass_q;
   logic              timer_clr, tick;

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk  (clk),
      .clr  (timer_clr),
      .en   (state_q == StRun),
      .tick (tick)
   );

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      tab_d     = tab_q;
      mm_d      = mm_q;
      timer_clr = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d   = StRun;
               data_d    = '0;
               tab_d     = '0;
               mm_d      = '0;
               timer_clr = 1'b1;
            end
         end
         StRun: begin
            if (tick) begin
               tab_d[data_q] = y;
               if (y != EXPECT[data_q]) begin
                  mm_d = mm_q + MW'(1);
               end
               // Last vector leaves data at its maximum rather than wrapping.
               if (data_q == {WIDTH{1'b1}}) begin
                  state_d = StDone;
               end else begin
                  data_d = data_q + WIDTH'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (rst) begin
         timer_clr = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         data_q  <= '0;
         tab_q   <= '0;
         mm_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         tab_q   <= tab_d;
         mm_q    <= mm_d;
         busy_q  <= (state_d == StRun);
         done_q  <= (state_d == StDone);
         pass_q  <= (state_d == StDone) && (mm_d == '0);
      end
   end

   assign data         = data_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign table_q      = tab_q;
   assign mismatch_cnt = mm_q;
   assign pass         = pass_q;

endmodule

// File: tb/tb_comb_sweep_driver.sv
// Directed bench for comb_sweep_driver: one instance with SETTLE=1 and one
// with SETTLE=3, both comparing against the (d3&d2)|(d1&d0) table 16'hF888.
module tb_comb_sweep_driver;

   logic        clk;
   logic        rst;
   logic        start1, start3;
   logic        y1, y3;
   logic        yzero1;
   logic [3:0]  data1, data3;
   logic        busy1, busy3, done1, done3, pass1, pass3;
   logic [15:0] tab1, tab3;
   logic [4:0]  mm1, mm3;

   int unsigned total;
   int unsigned passed;

   comb_sweep_driver #(
      .WIDTH  (4),
      .SETTLE (1),
      .EXPECT (16'hF888)
   ) dut1 (
      .clk          (clk),
      .rst          (rst),
      .start        (start1),
      .y            (y1),
      .data         (data1),
      .busy         (busy1),
      .done         (done1),
      .table_q      (tab1),
      .mismatch_cnt (mm1),
      .pass         (pass1)
   );

   comb_sweep_driver #(
      .WIDTH  (4),
      .SETTLE (3),
      .EXPECT (16'hF888)
   ) dut3 (
      .clk          (clk),
      .rst          (rst),
      .start        (start3),
      .y            (y3),
      .data         (data3),
      .busy         (busy3),
      .done         (done3),
      .table_q      (tab3),
      .mismatch_cnt (mm3),
      .pass         (pass3)
   );

   function automatic logic ref_y(input logic [3:0] d);
      return (d[3] & d[2]) | (d[1] & d[0]);
   endfunction

   always_comb begin
      y1 = yzero1 ? 1'b0 : ref_y(data1);
      y3 = ref_y(data3);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      total  = 0;
      passed = 0;
      rst    = 1'b1;
      start1 = 1'b0;
      start3 = 1'b0;
      yzero1 = 1'b0;
      step();
      step();
      rst = 1'b0;
      repeat (5) step();

      chk("rst_data", 32'(data1), 32'h0);
      chk("rst_busy", 32'(busy1), 32'h0);
      chk("rst_done", 32'(done1), 32'h0);
      chk("rst_table", 32'(tab1), 32'h0);
      chk("rst_mm", 32'(mm1), 32'h0);
      chk("rst_pass", 32'(pass1), 32'h0);
      chk("rst_busy3", 32'(busy3), 32'h0);

      // SETTLE=1, reference y: one vector per cycle.
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("s1_data", 32'(data1), 32'(i));
         chk("s1_busy", 32'(busy1), 32'h1);
         chk("s1_done", 32'(done1), 32'h0);
         step();
      end
      chk("s1_end_done", 32'(done1), 32'h1);
      chk("s1_end_busy", 32'(busy1), 32'h0);
      chk("s1_end_table", 32'(tab1), 32'hF888);
      chk("s1_end_mm", 32'(mm1), 32'h0);
      chk("s1_end_pass", 32'(pass1), 32'h1);
      chk("s1_end_data", 32'(data1), 32'hF);

      // Restart from DONE with y tied low: table clears on entry to RUN.
      yzero1 = 1'b1;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("y0_entry_table", 32'(tab1), 32'h0);
      chk("y0_entry_mm", 32'(mm1), 32'h0);
      chk("y0_entry_busy", 32'(busy1), 32'h1);
      chk("y0_entry_done", 32'(done1), 32'h0);
      chk("y0_entry_data", 32'(data1), 32'h0);
      repeat (15) step();
      // start coinciding with the RUN->DONE edge is ignored
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("y0_done", 32'(done1), 32'h1);
      chk("y0_table", 32'(tab1), 32'h0);
      chk("y0_mm", 32'(mm1), 32'h7);
      chk("y0_pass", 32'(pass1), 32'h0);
      step();
      chk("y0_hold_done", 32'(done1), 32'h1);
      chk("y0_hold_busy", 32'(busy1), 32'h0);
      chk("y0_hold_mm", 32'(mm1), 32'h7);

      // SETTLE=3 with a stray start pulse mid-sweep.
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      for (int c = 1; c <= 48; c++) begin
         chk("s3_data", 32'(data3), 32'((c - 1) / 3));
         chk("s3_busy", 32'(busy3), 32'h1);
         chk("s3_done", 32'(done3), 32'h0);
         start3 = (c == 10);
         step();
      end
      start3 = 1'b0;
      chk("s3_end_done", 32'(done3), 32'h1);
      chk("s3_end_busy", 32'(busy3), 32'h0);
      chk("s3_end_table", 32'(tab3), 32'hF888);
      chk("s3_end_mm", 32'(mm3), 32'h0);
      chk("s3_end_pass", 32'(pass3), 32'h1);

      // Reset at cycle 8 of a SETTLE=3 sweep.
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      repeat (7) step();
      chk("mid_data_pre", 32'(data3), 32'h2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_data", 32'(data3), 32'h0);
      chk("mid_busy", 32'(busy3), 32'h0);
      chk("mid_done", 32'(done3), 32'h0);
      chk("mid_table", 32'(tab3), 32'h0);
      chk("mid_mm", 32'(mm3), 32'h0);
      chk("mid_pass", 32'(pass3), 32'h0);
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      chk("re_data", 32'(data3), 32'h0);
      chk("re_busy", 32'(busy3), 32'h1);
      repeat (48) step();
      chk("re_done", 32'(done3), 32'h1);
      chk("re_table", 32'(tab3), 32'hF888);
      chk("re_mm", 32'(mm3), 32'h0);
      chk("re_pass", 32'(pass3), 32'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
